// File: rtl/axi_lsu_master.sv
// axi_lsu_master: AXI-lite initiator for the load/store unit, one transaction at a time.
// Places store data/strobes on byte lanes and extends load data from its lane.
module axi_lsu_master #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64
) (
    input  logic                    CLK,
    input  logic                    RESETN,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_wen,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [1:0]              req_size,
    input  logic                    req_unsigned,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    output logic                    resp_valid,
    output logic [DATA_WIDTH-1:0]   resp_rdata,
    output logic                    resp_misalign,
    output logic [ADDR_WIDTH-1:0]   AW_ADDR,
    output logic                    AW_VALID,
    input  logic                    AW_READY,
    output logic [DATA_WIDTH-1:0]   W_DATA,
    output logic [DATA_WIDTH/8-1:0] W_STRB,
    output logic                    W_VALID,
    input  logic                    W_READY,
    input  logic                    B_VALID,
    output logic                    B_READY,
    output logic [ADDR_WIDTH-1:0]   AR_ADDR,
    output logic                    AR_VALID,
    input  logic                    AR_READY,
    input  logic [DATA_WIDTH-1:0]   R_DATA,
    input  logic                    R_VALID,
    output logic                    R_READY
);
    localparam int NB = DATA_WIDTH / 8;

    typedef enum logic [2:0] {
        S_IDLE, S_AR, S_R, S_WR, S_B, S_RESP
    } state_t;

    state_t                  state_q, state_d;
    logic [2:0]              off_q;
    logic [1:0]              size_q;
    logic                    uns_q;
    logic                    aw_done_q, aw_done_d;
    logic                    w_done_q, w_done_d;
    logic                    mis_d;
    logic [DATA_WIDTH-1:0]   rdata_d;
    logic                    accept;
    logic [2:0]              req_off;
    logic [2:0]              size_mask;
    logic                    misaligned;
    logic [NB-1:0]           base_strb;
    logic [NB-1:0]           req_strb;
    logic [ADDR_WIDTH-1:0]   req_aligned;
    logic [DATA_WIDTH-1:0]   req_wdata_sh;

    assign req_off      = req_addr[2:0];
    assign accept       = (state_q == S_IDLE) && req_valid;
    assign req_aligned  = {req_addr[ADDR_WIDTH-1:3], 3'b000};
    assign misaligned   = |(req_off & size_mask);
    assign req_strb     = base_strb << req_off;
    assign req_wdata_sh = req_wdata << {req_off, 3'b000};

    always_comb begin
        size_mask = 3'b111;
        base_strb = '1;
        unique case (req_size)
            2'd0: begin size_mask = 3'b000; base_strb = NB'(8'h01); end
            2'd1: begin size_mask = 3'b001; base_strb = NB'(8'h03); end
            2'd2: begin size_mask = 3'b011; base_strb = NB'(8'h0F); end
            default: begin size_mask = 3'b111; base_strb = '1; end
        endcase
    end

    function automatic logic [DATA_WIDTH-1:0] load_ext(
        input logic [DATA_WIDTH-1:0] d,
        input logic [2:0]            off,
        input logic [1:0]            sz,
        input logic                  uns
    );
        logic [DATA_WIDTH-1:0] sh;
        sh = d >> {off, 3'b000};
        unique case (sz)
            2'd0: load_ext = {{(DATA_WIDTH-8){~uns & sh[7]}}, sh[7:0]};
            2'd1: load_ext = {{(DATA_WIDTH-16){~uns & sh[15]}}, sh[15:0]};
            2'd2: load_ext = {{(DATA_WIDTH-32){~uns & sh[31]}}, sh[31:0]};
            default: load_ext = sh;
        endcase
    endfunction

    always_comb begin
        state_d   = state_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        mis_d     = 1'b0;
        rdata_d   = '0;
        unique case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    if (misaligned) begin
                        state_d = S_RESP;
                        mis_d   = 1'b1;
                    end else begin
                        state_d = req_wen ? S_WR : S_AR;
                    end
                end
            end
            S_AR: if (AR_READY) state_d = S_R;
            S_R: begin
                if (R_VALID) begin
                    state_d = S_RESP;
                    rdata_d = load_ext(R_DATA, off_q, size_q, uns_q);
                end
            end
            S_WR: begin
                aw_done_d = aw_done_q | (AW_VALID & AW_READY);
                w_done_d  = w_done_q | (W_VALID & W_READY);
                if (aw_done_d && w_done_d) state_d = S_B;
            end
            S_B: if (B_VALID) state_d = S_RESP;
            S_RESP: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            state_q   <= S_IDLE;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end

    // Outputs are registered from the next state so they are glitch-free Moore values.
    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            req_ready     <= 1'b1;
            resp_valid    <= 1'b0;
            resp_rdata    <= '0;
            resp_misalign <= 1'b0;
            AW_ADDR       <= '0;
            AW_VALID      <= 1'b0;
            W_DATA        <= '0;
            W_STRB        <= '0;
            W_VALID       <= 1'b0;
            B_READY       <= 1'b0;
            AR_ADDR       <= '0;
            AR_VALID      <= 1'b0;
            R_READY       <= 1'b0;
            off_q         <= '0;
            size_q        <= '0;
            uns_q         <= 1'b0;
        end else begin
            req_ready     <= (state_d == S_IDLE);
            resp_valid    <= (state_d == S_RESP);
            resp_rdata    <= rdata_d;
            resp_misalign <= mis_d;
            AR_VALID      <= (state_d == S_AR);
            R_READY       <= (state_d == S_R);
            AW_VALID      <= (state_d == S_WR) && !aw_done_d;
            W_VALID       <= (state_d == S_WR) && !w_done_d;
            B_READY       <= (state_d == S_B);
            if (accept) begin
                off_q  <= req_off;
                size_q <= req_size;
                uns_q  <= req_unsigned;
                if (!misaligned && !req_wen) AR_ADDR <= req_aligned;
                if (!misaligned && req_wen) begin
                    AW_ADDR <= req_aligned;
                    W_DATA  <= req_wdata_sh;
                    W_STRB  <= req_strb;
                end
            end
        end
    end
endmodule

// File: tb/tb_axi_lsu_master.sv
// tb_axi_lsu_master: directed and random load/store requests against a
// byte-lane reference model, with a cycle-stepped AXI-lite slave.
module tb_axi_lsu_master;
    logic        CLK = 1'b0;
    logic        RESETN;
    logic        req_valid, req_ready, req_wen, req_unsigned;
    logic [63:0] req_addr, req_wdata;
    logic [1:0]  req_size;
    logic        resp_valid, resp_misalign;
    logic [63:0] resp_rdata;
    logic [63:0] AW_ADDR, W_DATA, AR_ADDR, R_DATA;
    logic [7:0]  W_STRB;
    logic        AW_VALID, AW_READY, W_VALID, W_READY;
    logic        B_VALID, B_READY, AR_VALID, AR_READY, R_VALID, R_READY;

    int n_chk = 0;
    int n_fail = 0;

    always #5 CLK = ~CLK;

    axi_lsu_master #(.ADDR_WIDTH(64), .DATA_WIDTH(64)) dut (
        .CLK(CLK), .RESETN(RESETN),
        .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
        .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_misalign(resp_misalign),
        .AW_ADDR(AW_ADDR), .AW_VALID(AW_VALID), .AW_READY(AW_READY),
        .W_DATA(W_DATA), .W_STRB(W_STRB), .W_VALID(W_VALID), .W_READY(W_READY),
        .B_VALID(B_VALID), .B_READY(B_READY),
        .AR_ADDR(AR_ADDR), .AR_VALID(AR_VALID), .AR_READY(AR_READY),
        .R_DATA(R_DATA), .R_VALID(R_VALID), .R_READY(R_READY)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] model_load(input logic [63:0] d, input logic [63:0] addr,
                                               input int size, input bit uns);
        int nb;
        int off;
        logic [63:0] v;
        nb = 1 << size;
        off = int'(addr % 8);
        v = '0;
        for (int i = 0; i < nb; i++) v[8*i +: 8] = d[8*(off+i) +: 8];
        if (!uns && nb < 8 && v[8*nb-1])
            for (int i = nb; i < 8; i++) v[8*i +: 8] = 8'hFF;
        return v;
    endfunction

    function automatic logic [7:0] model_strb(input logic [63:0] addr, input int size);
        logic [7:0] s;
        int off;
        s = '0;
        off = int'(addr % 8);
        for (int i = 0; i < (1 << size); i++) s[off+i] = 1'b1;
        return s;
    endfunction

    function automatic logic [63:0] model_wdata(input logic [63:0] wd, input logic [63:0] addr);
        logic [63:0] v;
        int off;
        v = '0;
        off = int'(addr % 8);
        for (int i = off; i < 8; i++) v[8*i +: 8] = wd[8*(i-off) +: 8];
        return v;
    endfunction

    task automatic chk_reset(input string tag);
        chk({tag, "_req_ready"}, req_ready, 1);
        chk({tag, "_resp_valid"}, resp_valid, 0);
        chk({tag, "_resp_rdata"}, resp_rdata, 0);
        chk({tag, "_resp_mis"}, resp_misalign, 0);
        chk({tag, "_ar_valid"}, AR_VALID, 0);
        chk({tag, "_ar_addr"}, AR_ADDR, 0);
        chk({tag, "_r_ready"}, R_READY, 0);
        chk({tag, "_aw_valid"}, AW_VALID, 0);
        chk({tag, "_aw_addr"}, AW_ADDR, 0);
        chk({tag, "_w_valid"}, W_VALID, 0);
        chk({tag, "_w_data"}, W_DATA, 0);
        chk({tag, "_w_strb"}, W_STRB, 0);
        chk({tag, "_b_ready"}, B_READY, 0);
    endtask

    task automatic do_req(
        input  logic        wen,
        input  logic [63:0] addr,
        input  logic [1:0]  size,
        input  logic        uns,
        input  logic [63:0] wdata,
        input  logic [63:0] rdata,
        input  int          ar_dly,
        input  int          r_dly,
        input  int          aw_dly,
        input  int          w_dly,
        input  int          b_dly,
        output logic [63:0] o_rdata,
        output logic [7:0]  o_strb,
        output logic [63:0] o_wdata,
        output int          o_lat,
        output int          o_awhi,
        output int          o_whi
    );
        int nb;
        bit mis;
        bit aw_done;
        bit w_done;
        int i;
        logic [63:0] aligned;
        nb = 1 << size;
        mis = (addr % nb) != 0;
        aligned = {addr[63:3], 3'b000};
        o_strb = '0;
        o_wdata = '0;
        o_awhi = 0;
        o_whi = 0;
        chk("idle_req_ready", req_ready, 1);
        req_valid = 1'b1;
        req_wen = wen;
        req_addr = addr;
        req_size = size;
        req_unsigned = uns;
        req_wdata = wdata;
        @(posedge CLK); #1;
        o_lat = 1;
        req_valid = 1'b0;
        if (mis) begin
            chk("mis_ar_valid", AR_VALID, 0);
            chk("mis_aw_valid", AW_VALID, 0);
            chk("mis_w_valid", W_VALID, 0);
        end else begin
            // a competing request that must be ignored outside IDLE
            req_valid = 1'b1;
            req_addr = addr ^ 64'h100;
            req_wen = ~wen;
            if (!wen) begin
                for (int k = 0; k <= ar_dly; k++) begin
                    chk("ar_valid", AR_VALID, 1);
                    chk("ar_addr", AR_ADDR, aligned);
                    chk("ar_rready", R_READY, 0);
                    chk("ar_awvalid", AW_VALID, 0);
                    AR_READY = (k == ar_dly);
                    @(posedge CLK); #1;
                    AR_READY = 1'b0;
                    o_lat++;
                end
                for (int k = 0; k <= r_dly; k++) begin
                    chk("r_ready", R_READY, 1);
                    chk("r_arvalid", AR_VALID, 0);
                    R_VALID = (k == r_dly);
                    R_DATA = (k == r_dly) ? rdata : {$urandom, $urandom};
                    @(posedge CLK); #1;
                    R_VALID = 1'b0;
                    o_lat++;
                end
            end else begin
                aw_done = 0;
                w_done = 0;
                i = 0;
                while (!(aw_done && w_done)) begin
                    chk("wr_aw_valid", AW_VALID, !aw_done);
                    chk("wr_w_valid", W_VALID, !w_done);
                    chk("wr_b_ready", B_READY, 0);
                    if (!aw_done) chk("wr_aw_addr", AW_ADDR, aligned);
                    if (!w_done) begin
                        chk("wr_w_data", W_DATA, model_wdata(wdata, addr));
                        chk("wr_w_strb", W_STRB, model_strb(addr, size));
                        o_strb = W_STRB;
                        o_wdata = W_DATA;
                    end
                    o_awhi += int'(AW_VALID);
                    o_whi += int'(W_VALID);
                    AW_READY = !aw_done && (i == aw_dly);
                    W_READY = !w_done && (i == w_dly);
                    @(posedge CLK); #1;
                    if (AW_READY) aw_done = 1;
                    if (W_READY) w_done = 1;
                    AW_READY = 1'b0;
                    W_READY = 1'b0;
                    i++;
                    o_lat++;
                end
                for (int k = 0; k <= b_dly; k++) begin
                    chk("b_ready", B_READY, 1);
                    chk("b_aw_valid", AW_VALID, 0);
                    chk("b_w_valid", W_VALID, 0);
                    B_VALID = (k == b_dly);
                    @(posedge CLK); #1;
                    B_VALID = 1'b0;
                    o_lat++;
                end
            end
        end
        req_valid = 1'b0;
        chk("resp_valid", resp_valid, 1);
        chk("resp_misalign", resp_misalign, mis);
        chk("resp_rdata", resp_rdata, (mis || wen) ? 64'h0 : model_load(rdata, addr, size, uns));
        chk("resp_req_ready", req_ready, 0);
        chk("resp_r_ready", R_READY, 0);
        chk("resp_b_ready", B_READY, 0);
        o_rdata = resp_rdata;
        @(posedge CLK); #1;
        chk("post_resp_valid", resp_valid, 0);
        chk("post_req_ready", req_ready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] o_rdata, o_wdata;
        logic [7:0]  o_strb;
        int          o_lat, o_awhi, o_whi;
        logic        wen, uns;
        logic [1:0]  sz;
        logic [63:0] addr;

        RESETN = 1'b0;
        req_valid = 0; req_wen = 0; req_unsigned = 0; req_size = 0;
        req_addr = 0; req_wdata = 0; R_DATA = 0;
        AW_READY = 0; W_READY = 0; B_VALID = 0; AR_READY = 0; R_VALID = 0;
        repeat (2) @(posedge CLK);
        #1;
        chk_reset("rst");
        RESETN = 1'b1;
        @(posedge CLK); #1;
        chk_reset("idle");

        do_req(0, 64'h8000_0003, 2'd0, 0, 64'h0, 64'h0000_0000_8000_0000,
               0, 0, 0, 0, 0, o_rdata, o_strb, o_wdata, o_lat, o_awhi, o_whi);
        chk("t1_rdata", o_rdata, 64'hFFFF_FFFF_FFFF_FF80);
        chk("t1_lat", o_lat, 3);

        do_req(1, 64'h8000_0006, 2'd1, 0, 64'h1234, 64'h0,
               0, 0, 0, 0, 0, o_rdata, o_strb, o_wdata, o_lat, o_awhi, o_whi);
        chk("t2_strb", o_strb, 8'hC0);
        chk("t2_wdata", o_wdata, 64'h1234_0000_0000_0000);
        chk("t2_lat", o_lat, 3);

        do_req(1, 64'h8000_0008, 2'd3, 0, 64'hCAFE_F00D_1234_5678, 64'h0,
               0, 0, 3, 0, 0, o_rdata, o_strb, o_wdata, o_lat, o_awhi, o_whi);
        chk("t3_awhi", o_awhi, 4);
        chk("t3_whi", o_whi, 1);
        chk("t3_lat", o_lat, 6);

        do_req(0, 64'h8000_0002, 2'd2, 0, 64'h0, 64'h0,
               0, 0, 0, 0, 0, o_rdata, o_strb, o_wdata, o_lat, o_awhi, o_whi);
        chk("t4_lat", o_lat, 1);

        do_req(0, 64'h8000_0004, 2'd2, 1, 64'h0, 64'h89AB_CDEF_0123_4567,
               0, 5, 0, 0, 0, o_rdata, o_strb, o_wdata, o_lat, o_awhi, o_whi);
        chk("t5_rdata", o_rdata, 64'h0000_0000_89AB_CDEF);
        chk("t5_lat", o_lat, 8);

        req_valid = 1; req_wen = 0; req_addr = 64'h8000_0010;
        req_size = 2'd3; req_unsigned = 0;
        @(posedge CLK); #1;
        req_valid = 0;
        AR_READY = 1;
        @(posedge CLK); #1;
        AR_READY = 0;
        chk("t6_r_ready", R_READY, 1);
        R_VALID = 1; R_DATA = 64'hDEAD_BEEF_DEAD_BEEF; RESETN = 0;
        @(posedge CLK); #1;
        RESETN = 1; R_VALID = 0;
        chk_reset("t6");
        @(posedge CLK); #1;
        chk_reset("t6_post");
        do_req(0, 64'h8000_0020, 2'd1, 0, 64'h0, 64'h0000_0000_0000_8001,
               1, 1, 0, 0, 0, o_rdata, o_strb, o_wdata, o_lat, o_awhi, o_whi);
        chk("t6_rdata", o_rdata, 64'hFFFF_FFFF_FFFF_8001);

        for (int n = 0; n < 60; n++) begin
            wen = 1'($urandom);
            uns = 1'($urandom);
            sz = 2'($urandom);
            addr = {$urandom, $urandom};
            if ($urandom_range(0, 3) != 0) addr = addr & ~((64'd1 << sz) - 64'd1);
            do_req(wen, addr, sz, uns, {$urandom, $urandom}, {$urandom, $urandom},
                   int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                   int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                   int'($urandom_range(0, 3)),
                   o_rdata, o_strb, o_wdata, o_lat, o_awhi, o_whi);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
